// File: rtl/sc_isa_pkg.sv
// Shared ISA constants for the single-cycle CPU: instruction kinds, opcodes,
// function codes, field positions and word-packing helpers.
package sc_isa_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,  K_SUB  = 5'd1,  K_GT   = 5'd2,  K_AND  = 5'd3,
    K_OR   = 5'd4,  K_XOR  = 5'd5,  K_SLL  = 5'd6,  K_SRL  = 5'd7,
    K_SRA  = 5'd8,  K_JR   = 5'd9,  K_ADDI = 5'd10, K_ANDI = 5'd11,
    K_ORI  = 5'd12, K_XORI = 5'd13, K_LW   = 5'd14, K_SW   = 5'd15,
    K_BEQ  = 5'd16, K_BNE  = 5'd17, K_LUI  = 5'd18, K_J    = 5'd19,
    K_JAL  = 5'd20
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_GT  = 6'b100111;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam int OP_MSB = 31, OP_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;
  localparam int SA_MSB = 10, SA_LSB = 6;
  localparam int FN_MSB = 5,  FN_LSB = 0;
  localparam int IM_MSB = 15, IM_LSB = 0;
  localparam int TG_MSB = 25, TG_LSB = 0;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    logic [31:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = OP_RTYPE;
    w[RS_MSB:RS_LSB] = rs;
    w[RT_MSB:RT_LSB] = rt;
    w[RD_MSB:RD_LSB] = rd;
    w[SA_MSB:SA_LSB] = sa;
    w[FN_MSB:FN_LSB] = fn;
    return w;
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = op;
    w[RS_MSB:RS_LSB] = rs;
    w[RT_MSB:RT_LSB] = rt;
    w[IM_MSB:IM_LSB] = imm;
    return w;
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = op;
    w[TG_MSB:TG_LSB] = target;
    return w;
  endfunction

endpackage

// File: rtl/sc_inst_pack.sv
// Combinational packer: instruction kind plus raw fields to a 32-bit word,
// with unused fields forced to zero and a legal flag for kinds 0..20.
module sc_inst_pack
  import sc_isa_pkg::*;
(
  input  logic [4:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  sa_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (kind_e'(kind_i))
      K_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      K_SUB:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
      K_GT:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_GT);
      K_AND:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
      K_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
      K_XOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
      K_SLL:  word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SLL);
      K_SRL:  word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SRL);
      K_SRA:  word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SRA);
      K_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      K_ADDI: word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
      K_ANDI: word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
      K_ORI:  word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
      K_XORI: word_o = i_word(OP_XORI, rs_i, rt_i, imm_i);
      K_LW:   word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
      K_SW:   word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
      K_BEQ:  word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
      K_BNE:  word_o = i_word(OP_BNE, rs_i, rt_i, imm_i);
      K_LUI:  word_o = i_word(OP_LUI, 5'd0, rt_i, imm_i);
      K_J:    word_o = j_word(OP_J, target_i);
      K_JAL:  word_o = j_word(OP_JAL, target_i);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_inst_encoder.sv
// Instruction encoder / IMEM loader. Handshake: a request is consumed on any
// cycle where in_valid_i & in_ready_o; a legal one is written one cycle later.
module sc_inst_encoder
  import sc_isa_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [4:0]    in_kind_i,
  input  logic [4:0]    in_rs_i,
  input  logic [4:0]    in_rt_i,
  input  logic [4:0]    in_rd_i,
  input  logic [4:0]    in_sa_i,
  input  logic [15:0]   in_imm_i,
  input  logic [25:0]   in_target_i,
  output logic          im_we_o,
  output logic [AW-1:0] im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          err_illegal_o,
  output enc_state_e    state_o
);

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = (AW+1)'(1);

  enc_state_e    state_q, state_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   count_q;
  logic          err_q;
  logic [31:0]   word;
  logic          legal;
  logic          full;
  logic          accept;
  logic          wr;
  logic          last_wr;

  sc_inst_pack u_pack (
    .kind_i   (in_kind_i),
    .rs_i     (in_rs_i),
    .rt_i     (in_rt_i),
    .rd_i     (in_rd_i),
    .sa_i     (in_sa_i),
    .imm_i    (in_imm_i),
    .target_i (in_target_i),
    .word_o   (word),
    .legal_o  (legal)
  );

  assign full    = (count_q == CAP);
  assign accept  = in_valid_i & in_ready_o;
  assign wr      = accept & legal;
  assign last_wr = wr & (count_q == CAP - ONE);

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // start beats stop everywhere; stop beats the final write's move to FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        if (start_i)      state_d = ST_LOAD;
        else if (stop_i)  state_d = ST_IDLE;
        else if (last_wr) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (start_i)     state_d = ST_LOAD;
        else if (stop_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == ST_LOAD) & ~full & ~start_i;
    state_o    = state_q;
  end

  // The word pointer is the low bits of count: both clear on start and step
  // together on every write, and FULL stops the pointer before it could wrap.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= wr;
      if (wr) begin
        addr_q  <= count_q[AW-1:0];
        wdata_q <= word;
      end
      if (start_i)                 count_q <= '0;
      else if (wr && count_q != CAP) count_q <= count_q + ONE;
      if (start_i)                 err_q <= 1'b0;
      else if (accept && !legal)   err_q <= 1'b1;
    end
  end

  assign im_we_o       = we_q;
  assign im_addr_o     = addr_q;
  assign im_wdata_o    = wdata_q;
  assign count_o       = count_q;
  assign full_o        = full;
  assign err_illegal_o = err_q;

endmodule

// File: tb/tb_sc_inst_encoder.sv
// Bench for sc_inst_encoder with a 4-word IMEM: expected writes are queued as
// requests are driven and popped as the DUT strobes im_we.
module tb_sc_inst_encoder;
  import sc_isa_pkg::*;

  localparam int AW  = 2;
  localparam int W   = AW + 32;
  localparam int CAP = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [4:0]    in_kind_i = '0;
  logic [4:0]    in_rs_i = '0;
  logic [4:0]    in_rt_i = '0;
  logic [4:0]    in_rd_i = '0;
  logic [4:0]    in_sa_i = '0;
  logic [15:0]   in_imm_i = '0;
  logic [25:0]   in_target_i = '0;
  logic          im_we_o;
  logic [AW-1:0] im_addr_o;
  logic [31:0]   im_wdata_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_illegal_o;
  enc_state_e    state_o;

  always #5 clock = ~clock;

  sc_inst_encoder #(.AW(AW)) u_dut (
    .clock_i       (clock),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_kind_i     (in_kind_i),
    .in_rs_i       (in_rs_i),
    .in_rt_i       (in_rt_i),
    .in_rd_i       (in_rd_i),
    .in_sa_i       (in_sa_i),
    .in_imm_i      (in_imm_i),
    .in_target_i   (in_target_i),
    .im_we_o       (im_we_o),
    .im_addr_o     (im_addr_o),
    .im_wdata_o    (im_wdata_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .err_illegal_o (err_illegal_o),
    .state_o       (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: {legal, word}.
  function automatic logic [32:0] model(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [15:0] imm, input logic [25:0] tgt);
    logic [5:0] code;
    case (kind)
      0: code = 6'h20;  1: code = 6'h22;  2: code = 6'h27;  3: code = 6'h24;
      4: code = 6'h25;  5: code = 6'h26;  6: code = 6'h00;  7: code = 6'h02;
      8: code = 6'h03;  9: code = 6'h08;  10: code = 6'h08; 11: code = 6'h0C;
      12: code = 6'h0D; 13: code = 6'h0E; 14: code = 6'h23; 15: code = 6'h2B;
      16: code = 6'h04; 17: code = 6'h05; 18: code = 6'h0F; 19: code = 6'h02;
      20: code = 6'h03; default: code = 6'h00;
    endcase
    if (kind <= 5)       return {1'b1, 6'b0, rs, rt, rd, 5'b0, code};
    else if (kind <= 8)  return {1'b1, 6'b0, 5'b0, rt, rd, sa, code};
    else if (kind == 9)  return {1'b1, 6'b0, rs, 15'b0, code};
    else if (kind <= 17) return {1'b1, code, rs, rt, imm};
    else if (kind == 18) return {1'b1, code, 5'b0, rt, imm};
    else if (kind <= 20) return {1'b1, code, tgt};
    return 33'b0;
  endfunction

  always @(negedge clock) begin : monitor
    logic [W-1:0] e;
    if (im_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_we", {63'b0, im_we_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", {{(64-AW){1'b0}}, im_addr_o}, {{(64-AW){1'b0}}, e[W-1:32]});
        check_eq("wr_data", {32'b0, im_wdata_o}, {32'b0, e[31:0]});
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    logic [AW-1:0] a;
    a = exp_ptr[AW-1:0];
    exp_q.push_back({a, w});
    exp_ptr++;
  endtask

  task automatic send(input logic [4:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] tgt, input int max_cyc, output bit acc);
    acc = 1'b0;
    @(negedge clock);
    in_valid_i = 1'b1;
    in_kind_i = kind; in_rs_i = rs; in_rt_i = rt; in_rd_i = rd;
    in_sa_i = sa; in_imm_i = imm; in_target_i = tgt;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      if (in_ready_o) acc = 1'b1;
      @(posedge clock);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid_i = 1'b0;
    stop_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    in_valid_i = 1'b0;
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    exp_ptr = 0;
    #1;
  endtask

  initial begin
    bit acc;
    bit any_ill;
    int k;
    logic [32:0] m;
    logic [4:0] f_rs, f_rt, f_rd, f_sa;
    logic [15:0] f_imm;
    logic [25:0] f_tgt;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_i = 1'b0;
    #1;
    check_eq("rst_ready", {63'b0, in_ready_o}, 0);
    check_eq("rst_we", {63'b0, im_we_o}, 0);
    check_eq("rst_addr", {62'b0, im_addr_o}, 0);
    check_eq("rst_wdata", {32'b0, im_wdata_o}, 0);
    check_eq("rst_count", {61'b0, count_o}, 0);
    check_eq("rst_full", {63'b0, full_o}, 0);
    check_eq("rst_err", {63'b0, err_illegal_o}, 0);
    check_eq("rst_state", {62'b0, state_o}, {62'b0, ST_IDLE});

    // add, with one-cycle write latency and a single-cycle strobe
    pulse_start();
    check_eq("start_state", {62'b0, state_o}, {62'b0, ST_LOAD});
    push_word(32'h00221820);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 4, acc);
    check_eq("add_acc", {63'b0, acc}, 1);
    idle();
    check_eq("add_we_n1", {63'b0, im_we_o}, 1);
    check_eq("add_count", {61'b0, count_o}, 1);
    @(negedge clock);
    check_eq("add_we_n2", {63'b0, im_we_o}, 0);

    // lw then sll with garbage rs
    pulse_start();
    push_word(32'h8CA4FFFC);
    send(5'd14, 5'd5, 5'd4, 5'd0, 5'd0, 16'hFFFC, 26'h0, 4, acc);
    check_eq("lw_acc", {63'b0, acc}, 1);
    push_word(32'h00031100);
    send(5'd6, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 4, acc);
    check_eq("sll_acc", {63'b0, acc}, 1);
    idle();

    // gt and j back-to-back; start lands while j's write is in flight
    pulse_start();
    push_word(32'h00430827);
    send(5'd2, 5'd2, 5'd3, 5'd1, 5'd0, 16'h0, 26'h0, 4, acc);
    check_eq("gt_acc", {63'b0, acc}, 1);
    push_word(32'h08000010);
    send(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1, acc);
    check_eq("j_b2b_acc", {63'b0, acc}, 1);
    pulse_start();
    check_eq("inflight_cnt", {61'b0, count_o}, 0);
    push_word(model(4, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0)
              [31:0]);
    send(5'd4, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 4, acc);
    idle();

    // illegal kind between two legal requests
    pulse_start();
    push_word(model(5, 5'd4, 5'd5, 5'd6, 5'd1, 16'h0, 26'h0)
              [31:0]);
    send(5'd5, 5'd4, 5'd5, 5'd6, 5'd1, 16'h0, 26'h0, 4, acc);
    send(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h0, 4, acc);
    check_eq("ill_acc", {63'b0, acc}, 1);
    push_word(model(9, 5'd31, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0)
              [31:0]);
    send(5'd9, 5'd31, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 4, acc);
    idle();
    check_eq("ill_err", {63'b0, err_illegal_o}, 1);
    check_eq("ill_count", {61'b0, count_o}, 2);

    // fill: 5 requests held valid, only 4 fit
    pulse_start();
    check_eq("start_clr_err", {63'b0, err_illegal_o}, 0);
    for (int i = 0; i < 4; i++) begin
      m = model(10 + i, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 257), 26'h0);
      push_word(m[31:0]);
      send(5'(10 + i), 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 257), 26'h0, 1, acc);
      check_eq("fill_acc", {63'b0, acc}, 1);
    end
    send(5'd18, 5'd3, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'h0, 6, acc);
    check_eq("fifth_acc", {63'b0, acc}, 0);
    idle();
    #1;
    check_eq("fill_full", {63'b0, full_o}, 1);
    check_eq("fill_count", {61'b0, count_o}, CAP);
    check_eq("fill_ready", {63'b0, in_ready_o}, 0);
    check_eq("fill_state", {62'b0, state_o}, {62'b0, ST_FULL});
    @(negedge clock);
    stop_i = 1'b1;
    @(negedge clock);
    stop_i = 1'b0;
    #1;
    check_eq("full_stop", {62'b0, state_o}, {62'b0, ST_IDLE});
    @(negedge clock);
    start_i = 1'b1;
    stop_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    stop_i = 1'b0;
    exp_ptr = 0;
    #1;
    check_eq("ss_state", {62'b0, state_o}, {62'b0, ST_LOAD});
    check_eq("ss_count", {61'b0, count_o}, 0);
    check_eq("ss_full", {63'b0, full_o}, 0);
    check_eq("ss_ready", {63'b0, in_ready_o}, 1);

    // start with in_valid: not accepted, no write
    @(negedge clock);
    in_valid_i = 1'b1; start_i = 1'b1; in_kind_i = 5'd0;
    #1;
    check_eq("start_v_ready", {63'b0, in_ready_o}, 0);
    @(negedge clock);
    in_valid_i = 1'b0; start_i = 1'b0;
    check_eq("start_v_we", {63'b0, im_we_o}, 0);

    // stop together with an accept: write issues, then IDLE
    push_word(model(18, 5'd9, 5'd8, 5'd0, 5'd0, 16'hABCD, 26'h0)
              [31:0]);
    @(negedge clock);
    stop_i = 1'b1; in_valid_i = 1'b1;
    in_kind_i = 5'd18; in_rs_i = 5'd9; in_rt_i = 5'd8; in_imm_i = 16'hABCD;
    #1;
    check_eq("stop_acc_ready", {63'b0, in_ready_o}, 1);
    idle();
    check_eq("stop_acc_we", {63'b0, im_we_o}, 1);
    check_eq("stop_acc_state", {62'b0, state_o}, {62'b0, ST_IDLE});

    // random legal/illegal mix through the model
    pulse_start();
    any_ill = 1'b0;
    for (int r = 0; r < 12 && exp_ptr < CAP; r++) begin
      k = $urandom_range(0, 31);
      f_rs = 5'($urandom); f_rt = 5'($urandom); f_rd = 5'($urandom); f_sa = 5'($urandom);
      f_imm = 16'($urandom); f_tgt = 26'($urandom);
      m = model(k, f_rs, f_rt, f_rd, f_sa, f_imm, f_tgt);
      if (m[32]) push_word(m[31:0]);
      else       any_ill = 1'b1;
      send(5'(k), f_rs, f_rt, f_rd, f_sa, f_imm, f_tgt, 4, acc);
      check_eq("rnd_acc", {63'b0, acc}, 1);
    end
    idle();
    check_eq("rnd_count", {61'b0, count_o}, 64'(exp_ptr));
    check_eq("rnd_err", {63'b0, err_illegal_o}, {63'b0, any_ill});

    // reset on the accept edge drops the write
    pulse_start();
    @(negedge clock);
    in_valid_i = 1'b1; reset_i = 1'b1; in_kind_i = 5'd1;
    @(negedge clock);
    in_valid_i = 1'b0; reset_i = 1'b0;
    check_eq("rstacc_we", {63'b0, im_we_o}, 0);
    check_eq("rstacc_state", {62'b0, state_o}, {62'b0, ST_IDLE});

    // reset during the write cycle clears everything the next cycle
    pulse_start();
    push_word(model(3, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0)
              [31:0]);
    send(5'd3, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 4, acc);
    @(negedge clock);
    in_valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clock);
    reset_i = 1'b0;
    check_eq("rst2_we", {63'b0, im_we_o}, 0);
    check_eq("rst2_addr", {62'b0, im_addr_o}, 0);
    check_eq("rst2_wdata", {32'b0, im_wdata_o}, 0);
    check_eq("rst2_count", {61'b0, count_o}, 0);

    repeat (3) @(negedge clock);
    check_eq("drain", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/sc_inst_encoder.md
# sc_inst_encoder

Sequential instruction encoder and instruction-memory loader for the single-cycle CPU. It accepts one symbolic instruction per handshake: a kind code plus rs/rt/rd/sa/imm/target fields. It packs each into the 32-bit word that the CPU control unit decodes, then writes the words to consecutive instruction-memory addresses. It sits between the test/program host and the IMEM write port, and runs while the CPU is held in reset.

## Interface
- AW, 6, IMEM word-address width; capacity 2^AW words
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: clear write pointer, enter LOAD
- stop  in  1  pulse: leave LOAD for IDLE
- in_valid  in  1  request valid
- in_ready  out  1  encoder accepts request this cycle
- in_kind  in  5  instruction kind 0..20; 21..31 illegal
- in_rs, in_rt, in_rd, in_sa  in  5 each  register/shamt fields
- in_imm  in  16  immediate/branch offset
- in_target  in  26  jump word target
- im_we  out  1  IMEM write strobe
- im_addr  out  AW  IMEM word address
- im_wdata  out  32  encoded instruction
- count  out  AW+1  words written since last start
- full  out  1  2^AW words written
- err_illegal  out  1  sticky: illegal kind seen since start

## Operation
- Kinds:
  - R-type (op 000000) with func: 0 add 100000, 1 sub 100010, 2 gt 100111, 3 and 100100, 4 or 100101, 5 xor 100110, 6 sll 000000, 7 srl 000010, 8 sra 000011, 9 jr 001000.
  - I-type with op: 10 addi 001000, 11 andi 001100, 12 ori 001101, 13 xori 001110, 14 lw 100011, 15 sw 101011, 16 beq 000100, 17 bne 000101, 18 lui 001111.
  - J-type with op: 19 j 000010, 20 jal 000011.
- Field packing: op[31:26], rs[25:21], rt[20:16], rd[15:11], sa[10:6], func[5:0]; imm[15:0]; target[25:0].
- Unused fields are forced to zero:
  - add/sub/gt/and/or/xor: sa=0.
  - shifts: rs=0.
  - jr: rt=rd=sa=0.
  - lui: rs=0.
- FSM states:
  - IDLE: in_ready=0. start → LOAD.
  - LOAD: in_ready = ~full. stop → IDLE. Final accepted write → FULL.
  - FULL: in_ready=0. start → LOAD. stop → IDLE.
- Accept happens when in_valid & in_ready. A legal kind is registered, and the write is issued next cycle at the current pointer; the pointer and count then increment.
- Illegal kind: the request is accepted (consumed), nothing is written, the pointer is unchanged, and err_illegal is set.
- start: pointer, count and err_illegal → 0.
- count saturates at 2^AW. full = (count == 2^AW).

## Timing
- Reset values:
  - state IDLE; in_ready 0; im_we 0; im_addr 0; im_wdata 0; count 0; full 0; err_illegal 0.
  - Reset mid-operation drops any pending write: im_we=0 the next cycle.
- Latency: accept at cycle N → im_we=1 for exactly one cycle at N+1, with im_addr and im_wdata stable that cycle. Throughput is one word per cycle.
- count and full update in the same cycle as the corresponding im_we.
- The final (2^AW-th) accept drives in_ready=0 from the next cycle on. The state enters FULL on that accept edge.
- Simultaneous events:
  - start with in_valid in LOAD: start wins, the request is not accepted, and in_ready=0 that cycle.
  - A write already in flight completes at its old address. The pointer still resets to 0.
  - stop with an accept: the accept is honoured and its write issues; then IDLE.
  - start and stop together: start wins.
- Pointer wrap never occurs; FULL blocks it.

## Structure
- Shared package sc_isa_pkg holds:
  - the kind enum (5-bit, values above);
  - opcode and func constants;
  - field bit positions.
- The CPU control unit migrates to these same constants.
- Sub-module sc_inst_pack: purely combinational kind+fields → 32-bit word plus a legal flag. The top level holds the FSM, pointer, count and output register.

## Test plan
- start; add rs=1 rt=2 rd=3 → im_we at N+1, addr 0, wdata 0x00221820.
- lw rs=5 rt=4 imm=0xFFFC, then sll rt=3 rd=2 sa=4 with garbage rs=7 → addr 0 gets 0x8CA4FFFC; addr 1 gets 0x00031100 (rs forced 0).
- gt rs=2 rt=3 rd=1, then j target=0x10, both back-to-back → 0x00430827 then 0x08000010 on consecutive cycles; count=2.
- kind=25 between two legal requests → no write for it; err_illegal=1; the legal words land at addr 0 and 1.
- AW=2: 5 requests held valid → 4 writes at addr 0..3; full=1; in_ready=0 after the 4th accept; the 5th is never accepted; start → count=0, state LOAD.
- Reset asserted the cycle after an accept → no im_we; all outputs return to their reset values.
